ulpi_reg_scan: RTL and testbench

// - Upstream sequencer for the ULPI register-read stage: walks an address range, issues one

---
 rtl/ulpi_reg_scan.sv | 135 +++++++++++++
 tb/tb_ulpi_reg_scan.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ulpi_reg_scan.sv
// ulpi_reg_scan: walks a ULPI register address range, issuing one read per register and
// queueing {addr,value} results in a small FIFO. Read watchdog: define ULPI_REG_SCAN_TIMEOUT_EN.
module ulpi_reg_scan #(
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk_ULPI,
    input  logic        rst,
    input  logic        START,
    input  logic [5:0]  ADDR_FIRST,
    input  logic [5:0]  ADDR_LAST,
    output logic        SCANNING,
    output logic        DONE,
    output logic        ERR,
    output logic        PrR,
    output logic [5:0]  ADDR,
    input  logic        busy,
    input  logic [7:0]  REG_VAL,
    output logic [13:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY
);
    localparam int AW = $clog2(FIFO_DEPTH);

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("ulpi_reg_scan: FIFO_DEPTH must be a power of two >= 2 and TIMEOUT_CYCLES >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE, S_ISSUE, S_WAIT_HI, S_WAIT_LO, S_STORE, S_NEXT, S_FIN
    } state_t;

    state_t        state_q, state_d;
    logic [5:0]    addr_q;
    logic [5:0]    last_q;
    logic [7:0]    res_q;
    logic [AW:0]   wptr_q, rptr_q;
    logic [13:0]   mem_q [FIFO_DEPTH];
    logic          start_acc, full, empty, push, pop, tmo_fire;

    assign start_acc = (state_q == S_IDLE) && START;
    assign empty     = (wptr_q == rptr_q);
    assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign pop       = !empty && OUT_READY;
    // A pop in the same cycle frees the slot the pending result needs.
    assign push      = (state_q == S_STORE) && (!full || pop);

`ifdef ULPI_REG_SCAN_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          err_q;
    logic          waiting, wait_exit;

    assign waiting   = (state_q == S_WAIT_HI) || (state_q == S_WAIT_LO);
    assign wait_exit = ((state_q == S_WAIT_HI) && busy) || ((state_q == S_WAIT_LO) && !busy);
    assign tmo_fire  = waiting && !wait_exit && (cnt_q >= CW'(TIMEOUT_CYCLES - 1));
    assign ERR       = err_q;

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state_q == S_ISSUE)
                cnt_q <= '0;
            else if (waiting)
                cnt_q <= cnt_q + 1'b1;
            if (start_acc)
                err_q <= 1'b0;
            else if (tmo_fire)
                err_q <= 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
    assign ERR      = 1'b0;
`endif

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start_acc) state_d = S_ISSUE;
            S_ISSUE:   state_d = S_WAIT_HI;
            S_WAIT_HI: if (busy) state_d = S_WAIT_LO;
                       else if (tmo_fire) state_d = S_STORE;
            S_WAIT_LO: if (!busy || tmo_fire) state_d = S_STORE;
            S_STORE:   if (push) state_d = S_NEXT;
            S_NEXT:    state_d = (addr_q == last_q) ? S_FIN : S_ISSUE;
            S_FIN:     state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        PrR       = (state_q == S_ISSUE);
        DONE      = (state_q == S_FIN);
        SCANNING  = (state_q != S_IDLE);
        ADDR      = addr_q;
        OUT_VALID = !empty;
        OUT_DATA  = empty ? 14'h0 : mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk_ULPI or negedge rst) begin
        if (!rst) begin
            addr_q <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            if (start_acc)
                addr_q <= ADDR_FIRST;
            else if (state_q == S_NEXT && addr_q != last_q)
                addr_q <= addr_q + 6'd1;
            if (push) wptr_q <= wptr_q + (AW + 1)'(1);
            if (pop)  rptr_q <= rptr_q + (AW + 1)'(1);
        end
    end

    // Scan limit, captured value and FIFO storage carry no reset; validity comes from control.
    always_ff @(posedge clk_ULPI) begin
        if (start_acc)
            last_q <= ADDR_LAST;
        if (state_q == S_WAIT_LO && !busy)
            res_q <= REG_VAL;
        else if (tmo_fire)
            res_q <= 8'hFF;
        if (push)
            mem_q[wptr_q[AW-1:0]] <= {addr_q, res_q};
    end

endmodule

// File: tb/tb_ulpi_reg_scan.sv
// Randomized bench for ulpi_reg_scan: reader model, expected-entry list per scan, per-cycle compare.
module tb_ulpi_reg_scan;
    localparam int DEPTH = 4;

    logic        clk_ULPI = 1'b0;
    logic        rst = 1'b0;
    logic        START = 1'b0;
    logic [5:0]  ADDR_FIRST = '0;
    logic [5:0]  ADDR_LAST = '0;
    logic        busy = 1'b0;
    logic [7:0]  REG_VAL = '0;
    logic        OUT_READY = 1'b0;
    logic        SCANNING, DONE, ERR, PrR, OUT_VALID;
    logic [5:0]  ADDR;
    logic [13:0] OUT_DATA;

    int          errs = 0;
    int          checks = 0;
    logic [7:0]  val_tab [64];
    logic [13:0] exp_q [$];
    logic [13:0] log_q [$];
    int          prr_idx = 0, pop_idx = 0;
    bit          done_seen = 0, fin_prev = 0;
    bit          clr_req = 0, clr_ack = 0;
    int          ready_mode = 0;
    bit          hang_en = 0;
    logic [5:0]  hang_addr = '0;
    int          rd_phase = 0, rd_cnt = 0;
    logic [5:0]  rd_addr = '0;

    ulpi_reg_scan #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(64)) dut (
        .clk_ULPI(clk_ULPI), .rst(rst), .START(START), .ADDR_FIRST(ADDR_FIRST),
        .ADDR_LAST(ADDR_LAST), .SCANNING(SCANNING), .DONE(DONE), .ERR(ERR), .PrR(PrR),
        .ADDR(ADDR), .busy(busy), .REG_VAL(REG_VAL), .OUT_DATA(OUT_DATA),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY)
    );

    always #5 clk_ULPI = ~clk_ULPI;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, expv, $time);
        end
    endtask

    // Register-read stage model: busy rises 0..2 cycles after PrR, holds 1..4 cycles.
    always @(negedge clk_ULPI) begin
        if (!rst) begin
            busy = 1'b0;
            rd_phase = 0;
        end else begin
            case (rd_phase)
                0: if (PrR) begin
                    rd_addr = ADDR;
                    REG_VAL = 8'($urandom);
                    rd_cnt = $urandom_range(0, 2);
                    rd_phase = 1;
                end
                1: if (rd_cnt == 0) begin
                    busy = 1'b1;
                    REG_VAL = val_tab[rd_addr];
                    rd_cnt = $urandom_range(0, 3);
                    rd_phase = 2;
                end else rd_cnt--;
                default: if (!(hang_en && rd_addr == hang_addr)) begin
                    if (rd_cnt == 0) begin
                        busy = 1'b0;
                        rd_phase = 0;
                    end else rd_cnt--;
                end
            endcase
        end
    end

    always @(posedge clk_ULPI) begin
        #1;
        OUT_READY = (ready_mode == 2) ? 1'($urandom_range(0, 1)) : (ready_mode == 1);
    end

    // Compare process: each read request and each pop is matched against the expected list.
    always @(negedge clk_ULPI) begin
        if (!rst || clr_req != clr_ack) begin
            prr_idx = 0;
            pop_idx = 0;
            done_seen = 0;
            fin_prev = 0;
            log_q.delete();
            clr_ack = clr_req;
        end else begin
            if (pop_idx == prr_idx) chk("valid_nothing_pending", OUT_VALID, 0);
            if (prr_idx - pop_idx > DEPTH + 1) chk("outstanding_bound", prr_idx - pop_idx, DEPTH + 1);
            if (fin_prev) chk("idle_after_done", {SCANNING, DONE}, 0);
            fin_prev = DONE;
            if (PrR) begin
                chk("prr_scanning", SCANNING, 1);
                if (prr_idx < exp_q.size()) chk("prr_addr", ADDR, exp_q[prr_idx][13:8]);
                else chk("prr_count", prr_idx + 1, exp_q.size());
                prr_idx++;
            end
            if (OUT_VALID && OUT_READY) begin
                if (pop_idx < exp_q.size()) chk("pop_data", OUT_DATA, exp_q[pop_idx]);
                else chk("pop_count", pop_idx + 1, exp_q.size());
                log_q.push_back(OUT_DATA);
                pop_idx++;
            end
            if (DONE) begin
                chk("done_all_issued", prr_idx, exp_q.size());
                done_seen = 1;
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_ULPI);
        #2;
    endtask

    task automatic start_scan(input logic [5:0] first, input logic [5:0] last);
        logic [5:0] a;
        exp_q.delete();
        a = first;
        forever begin
            exp_q.push_back({a, val_tab[a]});
            if (a == last) break;
            a = a + 6'd1;
        end
        clr_req = !clr_req;
        ADDR_FIRST = first;
        ADDR_LAST = last;
        tick(1);
        START = 1'b1;
        tick(1);
        START = 1'b0;
        ADDR_FIRST = 6'($urandom);
        ADDR_LAST = 6'($urandom);
    endtask

    task automatic wait_scan(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_seen && pop_idx == exp_q.size()) break;
            tick(1);
        end
        chk("scan_done", done_seen, 1);
        chk("scan_pops", pop_idx, exp_q.size());
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 64; i++) val_tab[i] = 8'($urandom);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [13:0] lit2 [4];
        logic [5:0]  lit_w [4];
        logic [5:0]  lit_r [3];
        logic [5:0]  f;
        int          k;
        lit2  = '{14'h00A5, 14'h01A4, 14'h02A7, 14'h03A6};
        lit_w = '{6'h3E, 6'h3F, 6'h00, 6'h01};
        lit_r = '{6'h10, 6'h11, 6'h12};
        rand_vals();

        tick(3);
        chk("reset_ctrl", {PrR, SCANNING, DONE, ERR, OUT_VALID}, 0);
        chk("reset_addr", ADDR, 0);
        chk("reset_data", OUT_DATA, 0);
        rst = 1'b1;
        tick(2);

        // Single register
        for (int i = 0; i < 64; i++) val_tab[i] = 8'hBA;
        ready_mode = 1;
        start_scan(6'h16, 6'h16);
        wait_scan(200);
        chk("single_count", log_q.size(), 1);
        if (log_q.size() > 0) chk("single_entry", log_q[0], 14'h16BA);
        chk("single_scanning", SCANNING, 0);

        // Range with XOR pattern
        for (int i = 0; i < 64; i++) val_tab[i] = 8'(i) ^ 8'hA5;
        start_scan(6'h00, 6'h03);
        wait_scan(300);
        chk("range_count", log_q.size(), 4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("range_entry", log_q[i], lit2[i]);

        // Back-pressure
        rand_vals();
        ready_mode = 0;
        start_scan(6'h00, 6'h05);
        tick(150);
        chk("bp_prr_held", prr_idx, 5);
        chk("bp_pops", pop_idx, 0);
        chk("bp_valid", OUT_VALID, 1);
        chk("bp_scanning", SCANNING, 1);
        ready_mode = 1;
        wait_scan(300);
        chk("bp_total", log_q.size(), 6);

        // Address wrap
        rand_vals();
        ready_mode = 2;
        start_scan(6'h3E, 6'h01);
        wait_scan(400);
        for (int i = 0; i < 4 && i < log_q.size(); i++) chk("wrap_addr", log_q[i][13:8], lit_w[i]);

        // Reset in WAIT_LO of second read
        ready_mode = 1;
        start_scan(6'h10, 6'h14);
        k = 0;
        while (!(prr_idx == 2 && busy) && k < 200) begin
            tick(1);
            k++;
        end
        chk("mid_reached", prr_idx, 2);
        rst = 1'b0;
        #1;
        chk("mid_reset_ctrl", {PrR, SCANNING, OUT_VALID}, 0);
        tick(2);
        rst = 1'b1;
        tick(2);
        start_scan(6'h10, 6'h12);
        wait_scan(300);
        chk("post_reset_count", log_q.size(), 3);
        for (int i = 0; i < 3 && i < log_q.size(); i++) chk("post_reset_addr", log_q[i][13:8], lit_r[i]);

`ifdef ULPI_REG_SCAN_TIMEOUT_EN
        // Reader hangs with busy high
        val_tab[6'h1B] = 8'hFF;
        hang_addr = 6'h1B;
        hang_en = 1;
        start_scan(6'h1B, 6'h1B);
        wait_scan(400);
        chk("tmo_err", ERR, 1);
        if (log_q.size() > 0) chk("tmo_entry", log_q[0], 14'h1BFF);
        hang_en = 0;
        tick(10);
        rand_vals();
        start_scan(6'h1B, 6'h1B);
        chk("tmo_err_cleared", ERR, 0);
        wait_scan(300);
`endif

        // Random scans
        for (int n = 0; n < 12; n++) begin
            rand_vals();
            ready_mode = $urandom_range(1, 2);
            f = 6'($urandom);
            start_scan(f, f + 6'($urandom_range(0, 7)));
            wait_scan(600);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
